// File: rtl/vend_pkg.sv
// Types and default parameters shared by the coin acceptor and the vending FSM.
package vend_pkg;

    // Denomination code handed between the coin front end and the vending FSM.
    typedef enum logic [1:0] {
        COIN_NONE    = 2'd0,
        COIN_NICKEL  = 2'd1,
        COIN_DIME    = 2'd2,
        COIN_QUARTER = 2'd3
    } coin_e;

    // Output sequencer states of the coin acceptor.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } acc_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_GAP_CYCLES      = 2;
    localparam int DEF_PEND_MAX        = 3;

endpackage

// File: rtl/coin_debounce.sv
// One coin-sensor input stage: 2-flop synchroniser, debounce counter and a
// rising-edge detector that yields a single-cycle coin event.
module coin_debounce
    import vend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sens,
    output logic evt
);

    localparam logic [7:0] CNT_TC = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync1;
    logic       sync2;
    logic [7:0] cnt;
    logic       level;
    logic       level_d;

    // Bring the raw asynchronous sensor into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= sens;
            sync2 <= sync1;
        end
    end

    // Flip the debounced level only after a full run of disagreeing samples;
    // a single agreeing sample restarts the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 8'd0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            cnt <= 8'd0;
        end else if (cnt == CNT_TC) begin
            cnt   <= 8'd0;
            level <= ~level;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    // Delayed copy of the debounced level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    // The event is combinational so the pending counter updates on the very
    // next edge after the debounced level rises.
    assign evt = level & ~level_d;

endmodule

// File: rtl/coin_acceptor.sv
// Coin front end: debounces three coin sensors, queues accepted coins per
// denomination and replays them as mutually exclusive one-cycle pulses,
// each followed by an idle gap.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | waiting; picks quarter > dime > nickel, takes one coin
//  PULSE | selected output high for exactly one cycle
//  GAP   | all outputs low for GAP_CYCLES cycles
module coin_acceptor
    import vend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
    parameter int PEND_MAX        = DEF_PEND_MAX
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sens_quarter,
    input  logic sens_dime,
    input  logic sens_nickel,
    input  logic accept_en,
    output logic quarter,
    output logic dime,
    output logic nickel,
    output logic reject,
    output logic busy
);

    localparam int                PEND_W    = $clog2(PEND_MAX + 1);
    localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(PEND_MAX);
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
    localparam logic [3:0]        GAP_LOAD  = 4'(GAP_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_PULSE = PULSE;
    localparam logic [1:0] ST_GAP   = GAP;

    // Channel index into the per-denomination vectors.
    localparam int CH_N = 0;
    localparam int CH_D = 1;
    localparam int CH_Q = 2;

    logic [2:0]        evt;
    logic [2:0]        inc;
    logic [2:0]        dec;
    logic [2:0]        drop;
    logic [PEND_W-1:0] pend     [3];
    logic [PEND_W-1:0] pend_nxt [3];

    logic [1:0] state;
    logic [1:0] state_nxt;
    coin_e      sel;
    coin_e      sel_nxt;
    logic [3:0] gap_tmr;
    logic [3:0] gap_tmr_nxt;
    logic       busy_nxt;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_quarter (
        .clk   (clk),
        .rst_n (rst_n),
        .sens  (sens_quarter),
        .evt   (evt[CH_Q])
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dime (
        .clk   (clk),
        .rst_n (rst_n),
        .sens  (sens_dime),
        .evt   (evt[CH_D])
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_nickel (
        .clk   (clk),
        .rst_n (rst_n),
        .sens  (sens_nickel),
        .evt   (evt[CH_N])
    );

    // Fixed-priority pick of the coin to replay; only taken from IDLE.
    always_comb begin
        dec = 3'b000;
        if (state == ST_IDLE) begin
            if (pend[CH_Q] != '0) begin
                dec[CH_Q] = 1'b1;
            end else if (pend[CH_D] != '0) begin
                dec[CH_D] = 1'b1;
            end else if (pend[CH_N] != '0) begin
                dec[CH_N] = 1'b1;
            end
        end
    end

    // Accept or drop each new coin; a full counter being drained this cycle
    // still has room for the new coin.
    always_comb begin
        inc      = 3'b000;
        drop     = 3'b000;
        pend_nxt = pend;
        for (int i = 0; i < 3; i++) begin
            inc[i]  = evt[i] && accept_en && ((pend[i] != PEND_FULL) || dec[i]);
            drop[i] = evt[i] && !inc[i];
            if (inc[i] && !dec[i]) begin
                pend_nxt[i] = pend[i] + PEND_ONE;
            end else if (dec[i] && !inc[i]) begin
                pend_nxt[i] = pend[i] - PEND_ONE;
            end
        end
    end

    // Output sequencer next-state logic; the gap timer is a down-counter.
    always_comb begin
        state_nxt   = state;
        sel_nxt     = sel;
        gap_tmr_nxt = gap_tmr;
        case (state)
            ST_IDLE: begin
                if (dec != 3'b000) begin
                    state_nxt = ST_PULSE;
                    sel_nxt   = dec[CH_Q] ? COIN_QUARTER :
                                dec[CH_D] ? COIN_DIME : COIN_NICKEL;
                end
            end
            ST_PULSE: begin
                state_nxt   = ST_GAP;
                gap_tmr_nxt = GAP_LOAD;
            end
            ST_GAP: begin
                if (gap_tmr == 4'd0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    gap_tmr_nxt = gap_tmr - 4'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Busy looks at next-state values so it drops on the same edge the
    // sequencer returns to IDLE with nothing left to replay.
    always_comb begin
        busy_nxt = (state_nxt != ST_IDLE);
        for (int i = 0; i < 3; i++) begin
            if (pend_nxt[i] != '0) begin
                busy_nxt = 1'b1;
            end
        end
    end

    // Pending counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                pend[i] <= '0;
            end
        end else begin
            pend <= pend_nxt;
        end
    end

    // Sequencer state, selected coin, gap timer and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            sel     <= COIN_NONE;
            gap_tmr <= 4'd0;
            busy    <= 1'b0;
            reject  <= 1'b0;
        end else begin
            state   <= state_nxt;
            sel     <= sel_nxt;
            gap_tmr <= gap_tmr_nxt;
            busy    <= busy_nxt;
            reject  <= |drop;
        end
    end

    // Decoded from flops only, so reset clears a pulse in progress at once.
    assign quarter = (state == ST_PULSE) && (sel == COIN_QUARTER);
    assign dime    = (state == ST_PULSE) && (sel == COIN_DIME);
    assign nickel  = (state == ST_PULSE) && (sel == COIN_NICKEL);

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with default parameters.
module tb_coin_acceptor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sens_quarter = 1'b0;
    logic sens_dime = 1'b0;
    logic sens_nickel = 1'b0;
    logic accept_en = 1'b1;
    logic quarter;
    logic dime;
    logic nickel;
    logic reject;
    logic busy;

    always #5 clk = ~clk;

    coin_acceptor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sens_quarter (sens_quarter),
        .sens_dime    (sens_dime),
        .sens_nickel  (sens_nickel),
        .accept_en    (accept_en),
        .quarter      (quarter),
        .dime         (dime),
        .nickel       (nickel),
        .reject       (reject),
        .busy         (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int cnt_q   = 0;
    int cnt_d   = 0;
    int cnt_n   = 0;
    int cnt_rej = 0;
    int multi   = 0;

    // Count pulses away from the active edge.
    always @(negedge clk) begin
        if (quarter === 1'b1) cnt_q++;
        if (dime === 1'b1) cnt_d++;
        if (nickel === 1'b1) cnt_n++;
        if (reject === 1'b1) cnt_rej++;
        if ((int'(quarter === 1'b1) + int'(dime === 1'b1) + int'(nickel === 1'b1)) > 1) multi++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_sens(input logic [2:0] m);
        {sens_quarter, sens_dime, sens_nickel} = m;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0] sens;   // {quarter, dime, nickel}
        int         hold;   // sampled-high cycles
        logic       acc;
        int         eq;
        int         ed;
        int         en;
        int         er;
    } vec_t;

    vec_t vecs [9];

    int q0, d0, n0, r0;
    int tq, td, tn;

    initial begin
        vecs[0] = '{3'b100,  10, 1'b1, 1, 0, 0, 0};  // clean quarter
        vecs[1] = '{3'b010,  10, 1'b1, 0, 1, 0, 0};  // clean dime
        vecs[2] = '{3'b001,  10, 1'b1, 0, 0, 1, 0};  // clean nickel
        vecs[3] = '{3'b001,   3, 1'b1, 0, 0, 0, 0};  // glitch below threshold
        vecs[4] = '{3'b001,   4, 1'b1, 0, 0, 1, 0};  // exactly at threshold
        vecs[5] = '{3'b111,  10, 1'b1, 1, 1, 1, 0};  // all three together
        vecs[6] = '{3'b010,  10, 1'b0, 0, 0, 0, 1};  // disabled dime
        vecs[7] = '{3'b101,  10, 1'b0, 0, 0, 0, 1};  // two drops, one reject
        vecs[8] = '{3'b100, 200, 1'b1, 1, 0, 0, 0};  // held high: one coin

        // Reset state
        cycles(3);
        chk("rst_quarter", 32'(quarter), 0);
        chk("rst_dime",    32'(dime),    0);
        chk("rst_nickel",  32'(nickel),  0);
        chk("rst_reject",  32'(reject),  0);
        chk("rst_busy",    32'(busy),    0);
        rst_n = 1'b1;
        cycles(5);

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            q0 = cnt_q; d0 = cnt_d; n0 = cnt_n; r0 = cnt_rej;
            accept_en = vecs[i].acc;
            set_sens(vecs[i].sens);
            cycles(vecs[i].hold);
            set_sens(3'b000);
            cycles(40);
            chk($sformatf("vec%0d_quarters", i), 32'(cnt_q - q0), 32'(vecs[i].eq));
            chk($sformatf("vec%0d_dimes", i),    32'(cnt_d - d0), 32'(vecs[i].ed));
            chk($sformatf("vec%0d_nickels", i),  32'(cnt_n - n0), 32'(vecs[i].en));
            chk($sformatf("vec%0d_rejects", i),  32'(cnt_rej - r0), 32'(vecs[i].er));
            chk($sformatf("vec%0d_busy_end", i), 32'(busy), 0);
            accept_en = 1'b1;
        end

        // Latency: quarter high only after the 8th edge that samples it
        q0 = cnt_q; r0 = cnt_rej;
        set_sens(3'b100);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            chk($sformatf("lat_quarter_k%0d", k), 32'(quarter), 32'(k == 8));
            if (k == 6) chk("lat_busy_k6", 32'(busy), 0);
            if (k == 7) chk("lat_busy_k7", 32'(busy), 1);
            if (k == 10) set_sens(3'b000);
        end
        cycles(40);
        chk("lat_total_quarters", 32'(cnt_q - q0), 1);
        chk("lat_rejects", 32'(cnt_rej - r0), 0);

        // Bounce on dime, then a steady press
        q0 = cnt_q; d0 = cnt_d; n0 = cnt_n; r0 = cnt_rej;
        for (int k = 0; k < 6; k++) begin
            sens_dime = (k % 2 == 0);
            cycles(1);
        end
        sens_dime = 1'b1;
        cycles(10);
        sens_dime = 1'b0;
        cycles(40);
        chk("bounce_dimes", 32'(cnt_d - d0), 1);
        chk("bounce_others", 32'(cnt_q - q0 + cnt_n - n0), 0);
        chk("bounce_rejects", 32'(cnt_rej - r0), 0);

        // Simultaneous: quarter, dime, nickel, each 4 cycles apart
        tq = -1; td = -1; tn = -1;
        set_sens(3'b111);
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            if (quarter === 1'b1) tq = k;
            if (dime === 1'b1) td = k;
            if (nickel === 1'b1) tn = k;
            if (k == 18) chk("simul_busy_k18", 32'(busy), 1);
            if (k == 19) chk("simul_busy_k19", 32'(busy), 0);
            if (k == 10) set_sens(3'b000);
        end
        chk("simul_t_quarter", 32'(tq), 8);
        chk("simul_t_dime",    32'(td), 12);
        chk("simul_t_nickel",  32'(tn), 16);
        cycles(20);

        // Saturation: five rounds of all three coins every 8 cycles; the
        // sequencer only serves two per round, so nickels pile up to 3 and
        // the 4th and 5th are rejected.
        q0 = cnt_q; d0 = cnt_d; n0 = cnt_n; r0 = cnt_rej;
        for (int r = 0; r < 5; r++) begin
            set_sens(3'b111);
            cycles(4);
            set_sens(3'b000);
            cycles(4);
        end
        cycles(60);
        chk("sat_quarters", 32'(cnt_q - q0), 5);
        chk("sat_dimes",    32'(cnt_d - d0), 5);
        chk("sat_nickels",  32'(cnt_n - n0), 3);
        chk("sat_rejects",  32'(cnt_rej - r0), 2);
        chk("sat_busy_end", 32'(busy), 0);

        // accept_en low: queued coins drain, a new dime is rejected
        q0 = cnt_q; d0 = cnt_d; n0 = cnt_n; r0 = cnt_rej;
        set_sens(3'b101);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (k == 2) sens_dime = 1'b1;
            if (k == 7) accept_en = 1'b0;
            if (k == 8) chk("dis_reject_k8", 32'(reject), 0);
            if (k == 9) chk("dis_reject_k9", 32'(reject), 1);
            if (k == 10) set_sens(3'b000);
        end
        cycles(40);
        chk("dis_quarters", 32'(cnt_q - q0), 1);
        chk("dis_nickels",  32'(cnt_n - n0), 1);
        chk("dis_dimes",    32'(cnt_d - d0), 0);
        chk("dis_rejects",  32'(cnt_rej - r0), 1);
        accept_en = 1'b1;
        cycles(5);

        // Reset during the dime pulse with a nickel still queued
        set_sens(3'b111);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 10) set_sens(3'b000);
        end
        chk("rstmid_dime_before", 32'(dime), 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_dime_after", 32'({quarter, dime, nickel, reject}), 0);
        chk("rstmid_busy_after", 32'(busy), 0);
        cycles(3);
        rst_n = 1'b1;
        q0 = cnt_q; d0 = cnt_d; n0 = cnt_n;
        cycles(40);
        chk("rstmid_no_pulses", 32'(cnt_q - q0 + cnt_d - d0 + cnt_n - n0), 0);

        chk("onehot_outputs", 32'(multi), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
